// File: rtl/data_mem.sv
// Byte/halfword/word data memory with registered reads,
// alignment/range checks and configurable wait states.
module data_mem #(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        ready,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  logic [31:0]   r_mem [DEPTH];
  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic          r_we;
  logic [1:0]    r_size;
  logic          r_uns;
  logic [31:0]   r_a;
  logic [31:0]   r_wd;
  logic [31:0]   r_rd;
  logic          r_ready;
  logic          r_err;

  logic [AW-1:0] w_idx;
  logic          w_err;
  logic          w_go;
  logic [31:0]   w_word;
  logic [31:0]   w_sh;
  logic [15:0]   w_half;
  logic [31:0]   w_load;
  logic [3:0]    w_mask;
  logic [31:0]   w_wdata;

  assign w_idx  = r_a[AW+1:2];
  assign w_word = r_mem[w_idx];
  assign w_go   = (r_state == S_BUSY) && (r_cnt == 4'd0);

  assign rd    = r_rd;
  assign ready = r_ready;
  assign err   = r_err;

  // Reject misaligned, illegal-size and out-of-range accesses
  always_comb begin
    w_err = 1'b0;
    if (r_size == 2'b11)
      w_err = 1'b1;
    if ((r_size == SZ_H) && r_a[0])
      w_err = 1'b1;
    if ((r_size == SZ_W) && (r_a[1:0] != 2'b00))
      w_err = 1'b1;
    if (|r_a[31:AW+2])
      w_err = 1'b1;
  end

  // Lane enables and lane-replicated store data
  always_comb begin
    w_mask  = 4'b0000;
    w_wdata = r_wd;
    case (r_size)
      SZ_B: begin
        w_mask  = 4'b0001 << r_a[1:0];
        w_wdata = {4{r_wd[7:0]}};
      end
      SZ_H: begin
        w_mask  = r_a[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{r_wd[15:0]}};
      end
      SZ_W: w_mask = 4'b1111;
      default: w_mask = 4'b0000;
    endcase
  end

  // Lane select and sign/zero extension for loads
  always_comb begin
    w_sh   = w_word >> {r_a[1:0], 3'b000};
    w_half = r_a[1] ? w_word[31:16] : w_word[15:0];
    w_load = w_word;
    case (r_size)
      SZ_B: w_load = r_uns ? {24'd0, w_sh[7:0]}
                           : {{24{w_sh[7]}}, w_sh[7:0]};
      SZ_H: w_load = r_uns ? {16'd0, w_half}
                           : {{16{w_half[15]}}, w_half};
      default: w_load = w_word;
    endcase
  end

  // Storage write on the final busy edge; not cleared by reset
  always_ff @(posedge clk) begin
    if (!reset && w_go && r_we && !w_err) begin
      for (int k = 0; k < 4; k++) begin
        if (w_mask[k])
          r_mem[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
      end
    end
  end

  // Request capture, wait-state count and completion
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rd    <= 32'd0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_we    <= we;
            r_size  <= size;
            r_uns   <= uns;
            r_a     <= a;
            r_wd    <= wd;
            r_cnt   <= 4'(WAIT_STATES);
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt == 4'd0) begin
            r_ready <= 1'b1;
            r_err   <= w_err;
            r_rd    <= (w_err || r_we) ? 32'd0 : w_load;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
